alu_instr_sequencer: RTL and testbench
======================================

Name: alu_instr_sequencer

Overview:
Upstream instruction sequencer for the single-cycle ALU/memory datapath. It holds a small writable instruction memory and runs a program counter. Each cycle it decodes one instruction word into the ALU operand, opcode, address and memory-op fields. It also supports halt and branch-if-zero, using the ALU result fed back to it.

Parameters:
IMEM_DEPTH, 16, number of instruction words (power of two)
PC_W, 4, program counter width, log2(IMEM_DEPTH)
CNT_W, 8, width of issued-instruction counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin execution at pc 0 (IDLE/HALT only)
prog_we  in  1  instruction memory write enable
prog_addr  in  PC_W  instruction memory write address
prog_data  in  16  instruction word to write
alu_y  in  3  ALU result Y fed back for branch decisions
A  out  2  ALU operand A
B  out  2  ALU operand B
Op  out  3  ALU opcode
Address  out  4  data memory address / branch target
MemOp  out  3  memory operation (000 = none)
pc  out  PC_W  current program counter
busy  out  1  high in RUN
halted  out  1  high in HALT
instr_count  out  CNT_W  instructions issued since start, saturating

Behaviour:
- Instruction word format:
  - [15:13] Op
  - [12:10] MemOp
  - [9:6] Address
  - [5:4] A
  - [3:2] B
  - [1:0] ctrl: 00 normal, 01 halt, 10 branch-if-zero, 11 reserved (treated as 00).
- States: IDLE, RUN, HALT.
- Reset: state IDLE, pc 0, A/B/Op/Address/MemOp 0, busy 0, halted 0, instr_count 0. Instruction memory contents are not cleared.
- Instruction memory:
  - Synchronous write when prog_we=1 and state != RUN.
  - prog_we in RUN is ignored (no write).
  - Read is combinational at pc.
- IDLE/HALT + start=1: next state RUN, pc <= 0, instr_count <= 0, halted <= 0.
- start in RUN is ignored.
- RUN, every edge, with w = imem[pc]:
  - ctrl 00/11:
    - All five fields registered onto outputs.
    - pc <= pc+1, wrapping IMEM_DEPTH-1 -> 0 with no stop.
    - instr_count increments.
  - ctrl 01:
    - Outputs registered with MemOp forced to 000.
    - State -> HALT, pc holds, instr_count increments.
  - ctrl 10:
    - Outputs registered with MemOp forced to 000.
    - If alu_y == 0, pc <= w[9:6] truncated/zero-extended to PC_W; else pc <= pc+1.
    - alu_y is sampled at that same edge and reflects the instruction issued on the previous cycle.
    - instr_count increments.
- Latency: instruction at pc appears on outputs one cycle after it is addressed. The start edge is followed by imem[0] fields after the next edge.
- instr_count saturates at 2^CNT_W-1.
- IDLE/HALT: outputs hold their last registered values except MemOp, which is forced to 000 at entry so the datapath never repeats a store.
- busy = (state == RUN); halted = (state == HALT). Both are registered with the state.
- prog_we and start in the same IDLE cycle: the write completes at that edge, and execution uses the updated contents.
- Reset asserted mid-RUN: at the next edge everything returns to reset values; any in-flight instruction is discarded.

Optional Feature:
STEP_MODE_EN:
- When defined: adds input port step (1 bit).
- In RUN the sequencer advances (fetch, output update, pc update, count) only on edges where step=1.
- On other RUN edges, pc and fields hold, MemOp is forced to 000, and the count holds.
- When undefined: no step port; RUN advances every cycle as above.

Test Plan:
- Reset then idle: assert reset 2 cycles -> all outputs 0, busy 0, halted 0. start without a program -> RUN, executing whatever is in memory (bench preloads all zeros -> Op 000, MemOp 000, pc cycles 0..15 and wraps to 0).
- Program load and linear run:
  - Load imem[0]=0x0018 (A=01, B=10, Op 000) and imem[1]=0x0458 (MemOp 001, Address 1); imem[2] is halt.
  - Pulse start -> cycle+1: A=01, B=10, Op=000, MemOp=000. Cycle+2: MemOp=001, Address=0001.
  - Cycle+3: MemOp=000, state HALT, halted=1, instr_count=3.
- Branch taken and not taken:
  - imem[3] ctrl 10, Address 0111, with alu_y=000 -> pc becomes 7.
  - Repeat with alu_y=011 -> pc becomes 4. MemOp=000 in both cases.
- Write protection: prog_we=1 to address 0 while busy=1 -> contents unchanged; a subsequent re-run shows the original word.
- Reset mid-run: assert reset while pc=5 -> next edge pc=0, MemOp=000, busy=0. A new start re-runs from pc 0 with memory intact.
- STEP_MODE_EN build: in RUN hold step=0 for 3 cycles -> pc constant, MemOp=000, instr_count constant. Pulse step=1 once -> exactly one instruction issued.

Source files
------------

// File: rtl/alu_instr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_instr_sequencer: instruction memory, PC and field decode for ALU/mem.  |
// | Optional macro STEP_MODE_EN adds a single-step input. Revision: 1.0        |
// +----------------------------------------------------------------------------+
module alu_instr_sequencer #(
  parameter int IMEM_DEPTH = 16,
  parameter int PC_W       = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             prog_we,
  input  logic [PC_W-1:0]  prog_addr,
  input  logic [15:0]      prog_data,
  input  logic [2:0]       alu_y,
`ifdef STEP_MODE_EN
  input  logic             step,
`endif
  output logic [1:0]       A,
  output logic [1:0]       B,
  output logic [2:0]       Op,
  output logic [3:0]       Address,
  output logic [2:0]       MemOp,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [1:0] CTRL_HALT   = 2'b01;
  localparam logic [1:0] CTRL_BRZERO = 2'b10;

  logic [15:0]      imem_q [IMEM_DEPTH];
  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [1:0]       a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d, memop_q, memop_d;
  logic [3:0]       addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, halted_q, halted_d;

  logic [15:0]      word;
  logic [1:0]       ctrl;
  logic [PC_W-1:0]  branch_target;
  logic             advance;

  // Memory is never cleared by reset; writes are locked out while running.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q != ST_RUN)) begin
      imem_q[prog_addr] <= prog_data;
    end
  end

  assign word          = imem_q[pc_q];
  assign ctrl          = word[1:0];
  assign branch_target = PC_W'(word[9:6]);

`ifdef STEP_MODE_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    addr_d  = addr_q;
    memop_d = memop_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (advance) begin
          a_d     = word[5:4];
          b_d     = word[3:2];
          op_d    = word[15:13];
          addr_d  = word[9:6];
          memop_d = word[12:10];
          cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          pc_d    = pc_q + PC_W'(1);
          if (ctrl == CTRL_HALT) begin
            memop_d = 3'b000;
            pc_d    = pc_q;
            state_d = ST_HALT;
          end else if (ctrl == CTRL_BRZERO) begin
            memop_d = 3'b000;
            if (alu_y == 3'b000) begin
              pc_d = branch_target;
            end
          end
        end else begin
          // A stalled cycle must not replay the previous store.
          memop_d = 3'b000;
        end
      end
      default: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
    endcase
    busy_d   = (state_d == ST_RUN);
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      memop_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      memop_q  <= memop_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign Op          = op_q;
  assign Address     = addr_q;
  assign MemOp       = memop_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign instr_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_instr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for alu_instr_sequencer: vector tables plus hand-written sequences,
// expected observations queued at drive time and popped after each edge.
module tb_alu_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = 4'd0;
  logic [15:0] prog_data = 16'd0;
  logic [2:0]  alu_y = 3'd0;
  logic        step = 1'b1;
  logic [1:0]  A, B;
  logic [2:0]  Op, MemOp;
  logic [3:0]  Address, pc;
  logic        busy, halted;
  logic [7:0]  instr_count;

  alu_instr_sequencer #(.IMEM_DEPTH(16), .PC_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .alu_y(alu_y),
`ifdef STEP_MODE_EN
    .step(step),
`endif
    .A(A), .B(B), .Op(Op), .Address(Address), .MemOp(MemOp), .pc(pc),
    .busy(busy), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] op;
    logic [3:0] addr;
    logic [2:0] memop;
    logic [3:0] pc;
    logic       busy;
    logic       halted;
    logic [7:0] cnt;
  } obs_t;

  typedef struct {
    logic       start;
    logic [2:0] alu_y;
    obs_t       exp;
  } vec_t;

  obs_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  vec_t lin[9];

  function automatic obs_t mk(input int a, input int b, input int op, input int ad,
                              input int mo, input int p, input int bz, input int hl,
                              input int c);
    obs_t o;
    o = '{a: 2'(a), b: 2'(b), op: 3'(op), addr: 4'(ad), memop: 3'(mo),
          pc: 4'(p), busy: 1'(bz), halted: 1'(hl), cnt: 8'(c)};
    return o;
  endfunction

  function automatic obs_t act();
    obs_t o;
    o = '{a: A, b: B, op: Op, addr: Address, memop: MemOp, pc: pc,
          busy: busy, halted: halted, cnt: instr_count};
    return o;
  endfunction

  task automatic check(input string nm);
    obs_t e;
    obs_t g;
    e = sb_q.pop_front();
    g = act();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: actual A=%0d B=%0d Op=%0d Addr=%0d MemOp=%0d pc=%0d busy=%0d halted=%0d cnt=%0d, required A=%0d B=%0d Op=%0d Addr=%0d MemOp=%0d pc=%0d busy=%0d halted=%0d cnt=%0d",
               nm, g.a, g.b, g.op, g.addr, g.memop, g.pc, g.busy, g.halted, g.cnt,
               e.a, e.b, e.op, e.addr, e.memop, e.pc, e.busy, e.halted, e.cnt);
    end
  endtask

  task automatic cycle_check(input logic st, input logic [2:0] ay, input obs_t e, input string nm);
    start = st;
    alu_y = ay;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    check(nm);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input int a, input logic [15:0] d);
    prog_we   = 1'b1;
    prog_addr = 4'(a);
    prog_data = d;
    idle_cycle();
    prog_we   = 1'b0;
  endtask

  // imem: 0=0x0018, 1=0x0458, 2=0x0000, 3=branch(Op5 MemOp2 Addr7 A1 B1), 4/7=halt
  task automatic branch_run(input logic [2:0] ay, input int tp, input string tag);
    cycle_check(1'b1, 3'd0, mk(0,0,0,0,0,0,1,0,0), {tag, "_start"});
    cycle_check(1'b0, 3'd0, mk(1,2,0,0,0,1,1,0,1), {tag, "_i0"});
    cycle_check(1'b0, 3'd0, mk(1,2,0,1,1,2,1,0,2), {tag, "_i1"});
    cycle_check(1'b0, ay,   mk(0,0,0,0,0,3,1,0,3), {tag, "_i2"});
    cycle_check(1'b0, ay,   mk(1,1,5,7,0,tp,1,0,4), {tag, "_branch"});
    cycle_check(1'b0, 3'd0, mk(0,0,0,0,0,tp,0,1,5), {tag, "_halt"});
  endtask

  initial begin
    lin[0] = '{1'b1, 3'd0, mk(0,0,0,0,0,0,1,0,0)};
    lin[1] = '{1'b0, 3'd0, mk(1,2,0,0,0,1,1,0,1)};
    lin[2] = '{1'b0, 3'd0, mk(1,2,0,1,1,2,1,0,2)};
    lin[3] = '{1'b0, 3'd0, mk(0,0,0,0,0,2,0,1,3)};
    lin[4] = '{1'b0, 3'd0, mk(0,0,0,0,0,2,0,1,3)};
    lin[5] = '{1'b1, 3'd0, mk(0,0,0,0,0,0,1,0,0)};
    lin[6] = '{1'b0, 3'd0, mk(1,2,0,0,0,1,1,0,1)};
    lin[7] = '{1'b0, 3'd0, mk(1,2,0,1,1,2,1,0,2)};
    lin[8] = '{1'b0, 3'd0, mk(0,0,0,0,0,2,0,1,3)};

    reset = 1'b1;
    idle_cycle();
    idle_cycle();
    sb_q.push_back(mk(0,0,0,0,0,0,0,0,0));
    check("reset_state");
    reset = 1'b0;

    // All-zero program: pc wraps freely and the counter saturates.
    for (int i = 0; i < 16; i++) prog(i, 16'h0000);
    cycle_check(1'b1, 3'd0, mk(0,0,0,0,0,0,1,0,0), "zrun_start");
    for (int k = 1; k <= 260; k++) begin
      cycle_check(1'b0, 3'd0, mk(0,0,0,0,0,k % 16,1,0,(k > 255) ? 255 : k),
                  $sformatf("zrun[%0d]", k));
    end
    reset = 1'b1;
    cycle_check(1'b0, 3'd0, mk(0,0,0,0,0,0,0,0,0), "zrun_reset");
    reset = 1'b0;

    // Linear run; imem[2]=halt is written on the same edge as start.
    prog(0, 16'h0018);
    prog(1, 16'h0458);
    prog_we   = 1'b1;
    prog_addr = 4'd2;
    prog_data = 16'h0001;
    for (int i = 0; i < 9; i++) begin
      cycle_check(lin[i].start, lin[i].alu_y, lin[i].exp, $sformatf("linear[%0d]", i));
      prog_we = 1'b0;
    end

    prog(2, 16'h0000);
    prog(3, 16'hA9D6);
    prog(4, 16'h0001);
    prog(7, 16'h0001);
    branch_run(3'd0, 7, "br_taken");
    branch_run(3'd3, 4, "br_not");

    // Writes attempted while running must be dropped.
    cycle_check(1'b1, 3'd0, mk(0,0,0,0,0,0,1,0,0), "wp_start");
    prog_we   = 1'b1;
    prog_addr = 4'd0;
    prog_data = 16'hFFFF;
    cycle_check(1'b0, 3'd0, mk(1,2,0,0,0,1,1,0,1), "wp_i0");
    cycle_check(1'b0, 3'd0, mk(1,2,0,1,1,2,1,0,2), "wp_i1");
    prog_we = 1'b0;
    cycle_check(1'b0, 3'd3, mk(0,0,0,0,0,3,1,0,3), "wp_i2");
    cycle_check(1'b0, 3'd3, mk(1,1,5,7,0,4,1,0,4), "wp_branch");
    cycle_check(1'b0, 3'd0, mk(0,0,0,0,0,4,0,1,5), "wp_halt");
    cycle_check(1'b1, 3'd0, mk(0,0,0,0,0,0,1,0,0), "wp_rerun_start");
    cycle_check(1'b0, 3'd0, mk(1,2,0,0,0,1,1,0,1), "wp_rerun_i0");
    alu_y = 3'd3;
    for (int i = 0; i < 4; i++) idle_cycle();
    alu_y = 3'd0;

    // Reset while pc=5 with a store on the outputs.
    prog(3, 16'h0000);
    prog(4, 16'h0458);
    cycle_check(1'b1, 3'd0, mk(0,0,0,0,0,0,1,0,0), "rm_start");
    cycle_check(1'b0, 3'd0, mk(1,2,0,0,0,1,1,0,1), "rm_i0");
    cycle_check(1'b0, 3'd0, mk(1,2,0,1,1,2,1,0,2), "rm_i1");
    cycle_check(1'b0, 3'd0, mk(0,0,0,0,0,3,1,0,3), "rm_i2");
    cycle_check(1'b0, 3'd0, mk(0,0,0,0,0,4,1,0,4), "rm_i3");
    cycle_check(1'b0, 3'd0, mk(1,2,0,1,1,5,1,0,5), "rm_i4");
    reset = 1'b1;
    cycle_check(1'b0, 3'd0, mk(0,0,0,0,0,0,0,0,0), "rm_reset");
    reset = 1'b0;
    cycle_check(1'b1, 3'd0, mk(0,0,0,0,0,0,1,0,0), "rm_restart");
    cycle_check(1'b0, 3'd0, mk(1,2,0,0,0,1,1,0,1), "rm_restart_i0");
    for (int i = 0; i < 6; i++) idle_cycle();
    cycle_check(1'b0, 3'd0, mk(0,0,0,0,0,7,0,1,8), "rm_halt7");

`ifdef STEP_MODE_EN
    cycle_check(1'b1, 3'd0, mk(0,0,0,0,0,0,1,0,0), "step_start");
    cycle_check(1'b0, 3'd0, mk(1,2,0,0,0,1,1,0,1), "step_i0");
    cycle_check(1'b0, 3'd0, mk(1,2,0,1,1,2,1,0,2), "step_i1");
    step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle_check(1'b0, 3'd0, mk(1,2,0,1,0,2,1,0,2), $sformatf("step_hold[%0d]", i));
    end
    step = 1'b1;
    cycle_check(1'b0, 3'd0, mk(0,0,0,0,0,3,1,0,3), "step_pulse");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
